// File: rtl/autobaud_uart_rx.sv
// Auto-baud UART 8N1 receiver: measures the bit period from a 0x55 calibration
// character, then delivers bytes on a valid/ready interface. Optional macro: AUTOBAUD_TIMEOUT_EN.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// CAL_WAIT  | unlocked, waiting for the calibration start-bit falling edge
// CAL_MEAS  | counting the calibration start-bit low time
// CAL_DRAIN | locked, discarding the rest of the calibration character
// IDLE      | locked, waiting for a start bit
// START     | timing to the middle of the start bit
// DATA      | sampling 8 data bits, LSB first
// STOP      | sampling the stop bit
// BREAK     | stop bit was low, waiting for the line to return high
module autobaud_uart_rx #(
    parameter int CNT_W       = 16,
    parameter int MIN_BIT     = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             locked,
    output logic [CNT_W-1:0] bit_period,
    output logic             frame_err,
    output logic             overrun
);

    if (CNT_W < 4 || MIN_BIT < 2 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 16777216) begin : g_bad_param
        $error("autobaud_uart_rx: parameter out of range");
    end

    localparam logic [CNT_W:0] CNT_SAT   = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W:0] MIN_BIT_W = (CNT_W+1)'(MIN_BIT);

    typedef enum logic [2:0] {
        CAL_WAIT,
        CAL_MEAS,
        CAL_DRAIN,
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state, state_n;
    logic             rx_meta, rx_sync, rx_prev;
    logic             fall, rise, tick;
    logic [CNT_W:0]   cnt, cnt_n;
    logic [CNT_W-1:0] tmr, tmr_n;
    logic [CNT_W-1:0] bp_n;
    logic             locked_n;
    logic [7:0]       shreg, shreg_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic             byte_done, stop_err;

`ifdef AUTOBAUD_TIMEOUT_EN
    localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYC - 1);
    logic [23:0] idle_cnt, idle_cnt_n;
`endif

    assign fall = rx_prev & ~rx_sync;
    assign rise = ~rx_prev & rx_sync;
    assign tick = (tmr == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CAL_WAIT;
            cnt        <= '0;
            tmr        <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            bit_period <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            tmr        <= tmr_n;
            shreg      <= shreg_n;
            bit_idx    <= bit_idx_n;
            bit_period <= bp_n;
            locked     <= locked_n;
        end
    end

`ifdef AUTOBAUD_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt_n;
        end
    end
`endif

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tmr_n     = tmr;
        shreg_n   = shreg;
        bit_idx_n = bit_idx;
        bp_n      = bit_period;
        locked_n  = locked;
        byte_done = 1'b0;
        stop_err  = 1'b0;
`ifdef AUTOBAUD_TIMEOUT_EN
        idle_cnt_n = '0;
`endif
        // Bit timer: samples land on tmr==0, then reload for exact spacing.
        if (state == START || state == DATA || state == STOP) begin
            tmr_n = tick ? (bit_period - 1'b1) : (tmr - 1'b1);
        end

        case (state)
            CAL_WAIT: begin
                if (fall) begin
                    state_n = CAL_MEAS;
                    cnt_n   = {{CNT_W{1'b0}}, 1'b1};
                end
            end
            CAL_MEAS: begin
                if (rise) begin
                    if (cnt >= MIN_BIT_W && cnt < CNT_SAT) begin
                        bp_n     = cnt[CNT_W-1:0];
                        locked_n = 1'b1;
                        cnt_n    = {cnt[CNT_W-1:0], 1'b0} - 1'b1;
                        state_n  = CAL_DRAIN;
                    end else begin
                        state_n = CAL_WAIT;
                    end
                end else if (!rx_sync && cnt < CNT_SAT) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CAL_DRAIN: begin
                // Need two full bit periods of continuous high to be past the character.
                if (!rx_sync) begin
                    cnt_n = {bit_period, 1'b0} - 1'b1;
                end else if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            IDLE: begin
                if (fall) begin
                    state_n = START;
                    tmr_n   = (bit_period >> 1) - 1'b1;
                end
`ifdef AUTOBAUD_TIMEOUT_EN
                else if (rx_sync) begin
                    if (idle_cnt == TIMEOUT_LAST) begin
                        state_n  = CAL_WAIT;
                        locked_n = 1'b0;
                        bp_n     = '0;
                    end else begin
                        idle_cnt_n = idle_cnt + 1'b1;
                    end
                end
`endif
            end
            START: begin
                if (tick) begin
                    if (rx_sync) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n   = {rx_sync, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_sync) begin
                        byte_done = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        stop_err = 1'b1;
                        state_n  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = CAL_WAIT;
            end
        endcase
    end

    // An accept in the delivery cycle frees the holding register for the new byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_err;
            overrun   <= byte_done & rx_valid & ~rx_ready;
            if (byte_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_autobaud_uart_rx.sv
// Directed bench for autobaud_uart_rx: calibration, byte delivery, framing error,
// overrun and glitch rejection; idle timeout when AUTOBAUD_TIMEOUT_EN is defined.
module tb_autobaud_uart_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        locked;
    logic [15:0] bit_period;
    logic        frame_err;
    logic        overrun;

    autobaud_uart_rx #(.CNT_W(16), .MIN_BIT(8), .TIMEOUT_CYC(1000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .locked     (locked),
        .bit_period (bit_period),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int         valid_rises = 0;
    int         ferr_pulses = 0;
    int         ovr_pulses  = 0;
    logic [7:0] cap_data    = 8'h00;
    logic       valid_q     = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid && !valid_q) begin
                valid_rises = valid_rises + 1;
                cap_data    = rx_data;
            end
            if (frame_err) ferr_pulses = ferr_pulses + 1;
            if (overrun)   ovr_pulses  = ovr_pulses + 1;
            valid_q = rx_valid;
        end else begin
            valid_q = 1'b0;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       ready;
        logic       glitch;
        logic       exp_rise;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];
    int   r0, f0, o0;
    logic vb, va;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; samples rx_valid just before and just after the delivery edge.
    task automatic send_frame(input logic [7:0] d, input int bl, input logic stop,
                              input logic ready_pulse, output logic v_before, output logic v_after);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        v_before = 1'b0;
        v_after  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == 9) begin
                step(bl / 2 + 2);
                v_before = rx_valid;
                if (ready_pulse) rx_ready = 1'b1;
                step(1);
                v_after = rx_valid;
                if (ready_pulse) rx_ready = 1'b0;
                step(bl - bl / 2 - 3);
            end else begin
                step(bl);
            end
        end
        rx = 1'b1;
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            d      stop  rdy   glt   rise  data   ferr
        vecs[0] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 0};
        vecs[1] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1};
        vecs[2] = '{8'h34, 1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 0};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 0};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 0};

        rx       = 1'b1;
        rx_ready = 1'b0;
        reset_n  = 1'b0;
        step(3);
        check("reset_locked", locked, 0);
        check("reset_bit_period", bit_period, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        reset_n = 1'b1;
        step(3);

        // Calibration pulse length boundaries
        rx = 1'b0; step(7); rx = 1'b1; step(20);
        check("cal7_locked", locked, 0);
        rx = 1'b0; step(3); rx = 1'b1; step(20);
        check("glitch3_locked", locked, 0);
        check("glitch3_bit_period", bit_period, 0);
        rx = 1'b0; step(8); rx = 1'b1; step(30);
        check("cal8_locked", locked, 1);
        check("cal8_bit_period", bit_period, 8);
        reset_n = 1'b0; step(2); reset_n = 1'b1; step(3);

        r0 = valid_rises; f0 = ferr_pulses;
        send_frame(8'h55, 32, 1'b1, 1'b0, vb, va);
        step(80);
        check("cal55_locked", locked, 1);
        check("cal55_bit_period", bit_period, 32);
        check("cal55_no_valid", valid_rises - r0, 0);
        check("cal55_no_ferr", ferr_pulses - f0, 0);

        for (int i = 0; i < 7; i++) begin
            r0 = valid_rises; f0 = ferr_pulses; o0 = ovr_pulses;
            rx_ready = vecs[i].ready;
            if (vecs[i].glitch) begin
                rx = 1'b0; step(5); rx = 1'b1; step(40);
                check($sformatf("v%0d_glitch_no_valid", i), valid_rises - r0, 0);
            end
            send_frame(vecs[i].d, 32, vecs[i].stop, 1'b0, vb, va);
            step(64);
            check($sformatf("v%0d_valid_count", i), valid_rises - r0, vecs[i].exp_rise);
            check($sformatf("v%0d_frame_err", i), ferr_pulses - f0, vecs[i].exp_ferr);
            check($sformatf("v%0d_overrun", i), ovr_pulses - o0, 0);
            if (vecs[i].exp_rise) begin
                check($sformatf("v%0d_data", i), cap_data, vecs[i].exp_data);
                check($sformatf("v%0d_latency", i), {vb, va}, 2'b01);
            end
            if (vecs[i].ready) begin
                check($sformatf("v%0d_auto_accept", i), rx_valid, 0);
            end else if (vecs[i].exp_rise) begin
                check($sformatf("v%0d_valid_held", i), rx_valid, 1);
                accept();
                check($sformatf("v%0d_valid_clear", i), rx_valid, 0);
                check($sformatf("v%0d_data_hold", i), rx_data, vecs[i].exp_data);
            end
            rx_ready = 1'b0;
        end

        // Overrun: second byte dropped while first is pending
        o0 = ovr_pulses;
        send_frame(8'h11, 32, 1'b1, 1'b0, vb, va);
        step(64);
        send_frame(8'h22, 32, 1'b1, 1'b0, vb, va);
        step(64);
        check("ovr_data_kept", rx_data, 8'h11);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_pulse", ovr_pulses - o0, 1);
        accept();
        check("ovr_accept_clear", rx_valid, 0);

        // Accept in the delivery cycle lets the new byte in
        o0 = ovr_pulses;
        send_frame(8'h11, 32, 1'b1, 1'b0, vb, va);
        step(64);
        send_frame(8'h22, 32, 1'b1, 1'b1, vb, va);
        step(64);
        check("same_cycle_data", rx_data, 8'h22);
        check("same_cycle_valid", {vb, va, rx_valid}, 3'b111);
        check("same_cycle_no_ovr", ovr_pulses - o0, 0);
        accept();
        check("same_cycle_clear", rx_valid, 0);

`ifdef AUTOBAUD_TIMEOUT_EN
        step(1100);
        check("timeout_locked", locked, 0);
        check("timeout_bit_period", bit_period, 0);
        r0 = valid_rises;
        send_frame(8'h55, 16, 1'b1, 1'b0, vb, va);
        step(60);
        check("recal_locked", locked, 1);
        check("recal_bit_period", bit_period, 16);
        check("recal_no_valid", valid_rises - r0, 0);
        send_frame(8'h7E, 16, 1'b1, 1'b0, vb, va);
        step(40);
        check("recal_7e_count", valid_rises - r0, 1);
        check("recal_7e_data", cap_data, 8'h7E);
        check("recal_7e_latency", {vb, va}, 2'b01);
        accept();
`else
        step(1200);
        check("no_timeout_locked", locked, 1);
        check("no_timeout_bit_period", bit_period, 32);
`endif

        // Reset mid-frame clears state without waiting for a clock edge
        rx = 1'b0;
        step(50);
        reset_n = 1'b0;
        #2;
        check("midframe_reset_locked", locked, 0);
        check("midframe_reset_bit_period", bit_period, 0);
        check("midframe_reset_valid", rx_valid, 0);
        rx = 1'b1;
        step(3);
        reset_n = 1'b1;
        step(5);
        check("post_reset_locked", locked, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
